imem_responder: RTL and testbench

- Instruction-memory responder for the fetch path: the responder end of the fetch interface driven by the PC stage.
- Accepts a fetch request carrying the current PC, waits a programmable number of cycles, then returns the 32-bit instruction word with a one-cycle ack, or an error for misaligned or out-of-range addresses.
- Holds a word-addressed instruction store filled through a separate load port, used by benches and the boot loader.

---
 rtl/imem_responder.sv | 178 +++++++++++++++++
 tb/tb_imem_responder.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch path.
// Answers one fetch at a time from a word-addressed store that is filled
// through a separate load port. After a programmable number of wait
// states it returns either the instruction word (ack) or an error for a
// misaligned or out-of-range address.
//
// Handshake: the master raises iport_cyc_i and iport_stb_i together. A
// request is accepted at a rising edge where both are high and the
// responder is IDLE. iport_cyc_i must stay high until the response. If
// iport_cyc_i drops during the wait phase, the request is abandoned with
// no response. The response is exactly one cycle of iport_ack_o or
// iport_err_o, never both. It is registered, so it appears one cycle
// after the FSM enters RESP. The FSM has already returned to IDLE by then,
// so a master that keeps stb high is accepted again at the edge where ack
// drops.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  localparam int unsigned AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [31:0]   iport_addr_i,
  input  logic          iport_cyc_i,
  input  logic          iport_stb_i,
  output logic [31:0]   iport_data_o,
  output logic          iport_ack_o,
  output logic          iport_err_o,
  input  logic          ld_we_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [31:0]   ld_data_i,
  output logic          busy_o,
  output logic [1:0]    dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

  // Instruction store (not reset; contents survive rst_i)
  logic [31:0] mem_q [DEPTH_WORDS];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        fault_q, fault_d;
  logic [31:0] word_q, word_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] data_q, data_d;
  logic        busy_q, busy_d;

  // Request decode
  logic        req_fire;
  logic [31:0] req_off;
  logic        req_misaligned;
  logic        req_out_of_range;
  logic        req_fault;
  logic [31:0] rd_word;
  logic        unused_off_bits;

  // Address offset from the base; the subtraction wraps, so addresses below
  // BASE_ADDR land far beyond the store and fault as out of range.
  assign req_off          = iport_addr_i - BASE_ADDR;
  assign req_misaligned   = (iport_addr_i[1:0] != 2'b00);
  assign req_out_of_range = ({2'b00, req_off[31:2]} >= 32'(DEPTH_WORDS));
  assign req_fault        = req_misaligned | req_out_of_range;
  assign req_fire         = iport_cyc_i & iport_stb_i;
  assign unused_off_bits  = ^req_off[1:0];

  // Word read at the acceptance edge. The store is written with a
  // non-blocking update, so a same-edge load-port write is not visible here
  // and the fetch returns the old word.
  assign rd_word = mem_q[req_off[AW+1:2]];

  // Load port: writes the store at any time, independent of the FSM
  always_ff @(posedge clk_i) begin
    if (ld_we_i) begin
      mem_q[ld_addr_i] <= ld_data_i;
    end
  end

  // State, counter and captured-request registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      fault_q <= 1'b0;
      word_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      word_q  <= word_d;
    end
  end

  // Next-state logic: accept, count wait states, respond, return to idle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    word_d  = word_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          fault_d = req_fault;
          // The word is captured only for a good address. After a fault the
          // previous capture is kept, because the error path returns zero.
          if (!req_fault) begin
            word_d = rd_word;
          end
          cnt_d   = WS_CNT;
          state_d = (WS_CNT != 4'd0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (!iport_cyc_i) begin
          // Master abandoned the cycle: drop the request silently
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        // cyc/stb are ignored here; the response always completes
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output decode: response pulse, returned data and busy flag
  always_comb begin
    ack_d  = 1'b0;
    err_d  = 1'b0;
    data_d = data_q;
    busy_d = (state_d != ST_IDLE);
    if (state_q == ST_RESP) begin
      ack_d  = ~fault_q;
      err_d  = fault_q;
      data_d = fault_q ? 32'h0 : word_q;
    end
  end

  // Registered bus outputs; data holds its last value between responses
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      data_q <= 32'h0;
      busy_q <= 1'b0;
    end else begin
      ack_q  <= ack_d;
      err_q  <= err_d;
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign iport_ack_o  = ack_q;
  assign iport_err_o  = err_q;
  assign iport_data_o = data_q;
  assign busy_o       = busy_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder. Two instances share the clock, reset and load
// port. Instance 0 has 2 wait states and base 0. Instance 1 has 0 wait
// states and base 0x1000. A reference model of the store predicts each
// response's kind, data and arrival edge. A monitor compares the outputs
// against that prediction on every falling edge.
module tb_imem_responder;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // ---------------- DUT signals ----------------
  logic [1:0]    f_cyc, f_stb;
  logic [31:0]   f_addr [2];
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic [1:0]    ack, err, busy;
  logic [31:0]   dout [2];
  logic [1:0]    dbg0, dbg1;

  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2), .BASE_ADDR(32'h0000_0000)) u_dut0 (
    .clk_i(clk), .rst_i(rst_n),
    .iport_addr_i(f_addr[0]), .iport_cyc_i(f_cyc[0]), .iport_stb_i(f_stb[0]),
    .iport_data_o(dout[0]), .iport_ack_o(ack[0]), .iport_err_o(err[0]),
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
    .busy_o(busy[0]), .dbg_state_o(dbg0)
  );

  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .BASE_ADDR(32'h0000_1000)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n),
    .iport_addr_i(f_addr[1]), .iport_cyc_i(f_cyc[1]), .iport_stb_i(f_stb[1]),
    .iport_data_o(dout[1]), .iport_ack_o(ack[1]), .iport_err_o(err[1]),
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
    .busy_o(busy[1]), .dbg_state_o(dbg1)
  );

  // ---------------- reference model ----------------
  logic [31:0] model_mem [DEPTH];
  logic [31:0] hold_data [2];
  // entry = {due_edge[31:0], is_err, data[31:0]}
  logic [64:0] exp_q0[$];
  logic [64:0] exp_q1[$];
  int errors = 0;
  int checks = 0;

  function automatic int ws_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0000_0000 : 32'h0000_1000;
  endfunction

  function automatic bit good_addr(input int d, input logic [31:0] a);
    logic [31:0] off;
    off = a - base_of(d);
    return (a % 4 == 0) && ((off / 4) < DEPTH);
  endfunction

  function automatic logic [AW-1:0] idx_of(input int d, input logic [31:0] a);
    logic [31:0] off;
    off = (a - base_of(d)) / 4;
    return off[AW-1:0];
  endfunction

  function automatic logic [64:0] predict(input int d, input logic [31:0] a, input int k);
    logic [31:0] w;
    bit bad;
    bad = !good_addr(d, a);
    w = 32'h0;
    if (!bad) w = model_mem[idx_of(d, a)];
    return {32'(k + 1 + ws_of(d)), bad, w};
  endfunction

  function automatic void push_exp(input int d, input logic [64:0] e);
    if (d == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endfunction

  // ---------------- monitor / scoreboard ----------------
  task automatic mon(input int d);
    logic [64:0] e;
    bit have;
    have = (d == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
    e = '0;
    if (have) e = (d == 0) ? exp_q0[0] : exp_q1[0];
    if (ack[d] || err[d]) begin
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL unexpected_resp dut%0d: ack=%0b err=%0b data=%h at edge %0d, required no response",
                 d, ack[d], err[d], dout[d], edge_n);
      end else begin
        if (d == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
        if (ack[d] !== ~e[32] || err[d] !== e[32] || dout[d] !== e[31:0] || edge_n != int'(e[64:33])) begin
          errors++;
          $display("FAIL resp dut%0d: got ack=%0b err=%0b data=%h edge=%0d, required ack=%0b err=%0b data=%h edge=%0d",
                   d, ack[d], err[d], dout[d], edge_n, ~e[32], e[32], e[31:0], int'(e[64:33]));
        end
        hold_data[d] = e[31:0];
      end
    end else begin
      if (have && int'(e[64:33]) <= edge_n) begin
        checks++;
        errors++;
        $display("FAIL missing_resp dut%0d: got none at edge %0d, required err=%0b data=%h at edge %0d",
                 d, edge_n, e[32], e[31:0], int'(e[64:33]));
        if (d == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
        hold_data[d] = e[31:0];
      end
      checks++;
      if (dout[d] !== hold_data[d]) begin
        errors++;
        $display("FAIL data_hold dut%0d: got %h, required %h at edge %0d", d, dout[d], hold_data[d], edge_n);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  task automatic check1(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0b, required %0b at edge %0d", name, got, want, edge_n);
    end
  endtask

  // ---------------- driver tasks (start and end at a falling edge) ----------------
  task automatic load(input logic [AW-1:0] idx, input logic [31:0] data);
    ld_we = 1'b1; ld_addr = idx; ld_data = data;
    @(posedge clk);
    model_mem[idx] = data;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  // n fetches from a0 with stb held high; optional same-edge load write on
  // the first fetch, and optional write to the last index while it waits.
  task automatic fetch_seq(input int d, input logic [31:0] a0, input int n,
                           input bit collide, input logic [31:0] cdata, input bit wwait);
    logic [31:0] a, la;
    logic [AW-1:0] li;
    int e, k, w;
    bit wr;
    w = ws_of(d);
    la = a0;
    for (int i = 0; i < n; i++) begin
      a = a0 + 32'(4 * i);
      f_cyc[d] = 1'b1; f_stb[d] = 1'b1; f_addr[d] = a;
      e = edge_n;
      wr = 1'b0;
      if (i == 0 && collide && good_addr(d, a)) begin
        ld_we = 1'b1; ld_addr = idx_of(d, a); ld_data = cdata; wr = 1'b1;
      end
      if (i == 0) begin
        k = e + 1;
        @(posedge clk);
      end else begin
        k = e + w + 2;
        repeat (w + 2) @(posedge clk);
      end
      push_exp(d, predict(d, a, k));
      if (wr) model_mem[idx_of(d, a)] = cdata;
      @(negedge clk);
      ld_we = 1'b0;
      check1($sformatf("busy_accept dut%0d", d), busy[d], 1'b1);
      la = a;
    end
    f_stb[d] = 1'b0;
    if (wwait && good_addr(d, la)) begin
      li = idx_of(d, la);
      ld_we = 1'b1; ld_addr = li; ld_data = $urandom;
      @(posedge clk);
      model_mem[li] = ld_data;
      @(negedge clk);
      ld_we = 1'b0;
      repeat (w + 1) @(negedge clk);
    end else begin
      repeat (w + 2) @(negedge clk);
    end
    check1($sformatf("busy_done dut%0d", d), busy[d], 1'b0);
    f_cyc[d] = 1'b0;
  endtask

  task automatic fetch1(input int d, input logic [31:0] a);
    fetch_seq(d, a, 1, 1'b0, 32'h0, 1'b0);
  endtask

  // Request on instance 0, then drop cyc during the wait phase
  task automatic abort0(input logic [31:0] a);
    f_cyc[0] = 1'b1; f_stb[0] = 1'b1; f_addr[0] = a;
    @(posedge clk);
    @(negedge clk);
    f_cyc[0] = 1'b0; f_stb[0] = 1'b0;
    check1("busy_abort_wait", busy[0], 1'b1);
    @(negedge clk);
    check1("busy_abort_idle", busy[0], 1'b0);
    repeat (4) begin
      @(negedge clk);
      check1("no_ack_abort", ack[0], 1'b0);
      check1("no_err_abort", err[0], 1'b0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check1($sformatf("%s_ack dut%0d", tag, d), ack[d], 1'b0);
      check1($sformatf("%s_err dut%0d", tag, d), err[d], 1'b0);
      check1($sformatf("%s_busy dut%0d", tag, d), busy[d], 1'b0);
      checks++;
      if (dout[d] !== 32'h0) begin
        errors++;
        $display("FAIL %s_data dut%0d: got %h, required 00000000", tag, d, dout[d]);
      end
    end
  endtask

  // Reset asserted while instance 0 is in its wait phase
  task automatic reset_mid_wait();
    f_cyc[0] = 1'b1; f_stb[0] = 1'b1; f_addr[0] = 32'h4;
    @(posedge clk);
    @(negedge clk);
    f_stb[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    hold_data[0] = 32'h0;
    hold_data[1] = 32'h0;
    f_cyc[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d, r, n;
    logic [31:0] a;
    rst_n = 1'b0;
    f_cyc = 2'b00; f_stb = 2'b00;
    f_addr[0] = 32'h0; f_addr[1] = 32'h0;
    ld_we = 1'b0; ld_addr = '0; ld_data = 32'h0;
    hold_data[0] = 32'h0; hold_data[1] = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    load(6'd0, 32'h0000_0013);
    load(6'd1, 32'h0010_0093);
    load(6'd2, 32'h0020_0113);
    load(6'd3, 32'h0030_8193);
    for (int i = 4; i < DEPTH; i++) load(AW'(i), $urandom);

    // Instance 0 directed
    fetch1(0, 32'h4);
    fetch_seq(0, 32'h0, 4, 1'b0, 32'h0, 1'b0);
    fetch1(0, 32'h6);
    fetch1(0, 32'(4 * DEPTH));
    abort0(32'h8);
    fetch1(0, 32'h8);
    fetch_seq(0, 32'h4, 1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    fetch1(0, 32'h4);
    fetch_seq(0, 32'hC, 1, 1'b0, 32'h0, 1'b1);

    // Instance 1 directed (no wait states, base 0x1000)
    fetch1(1, 32'h1004);
    fetch_seq(1, 32'h1000, 4, 1'b0, 32'h0, 1'b0);
    fetch1(1, 32'h1002);
    fetch1(1, 32'h1000 + 32'(4 * DEPTH));
    fetch1(1, 32'h0);
    fetch1(1, 32'h0FFC);
    fetch1(1, 32'h1000 + 32'(4 * (DEPTH - 1)));
    fetch_seq(1, 32'h1008, 1, 1'b1, 32'hCAFE_F00D, 1'b0);
    fetch1(1, 32'h1008);

    // Reset during a wait phase, then normal service on both
    fetch1(0, 32'h4);
    reset_mid_wait();
    fetch1(0, 32'h0);
    fetch1(1, 32'h1000);
    fetch_seq(1, 32'h1004, 2, 1'b0, 32'h0, 1'b0);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      d = $urandom_range(0, 1);
      r = $urandom_range(0, 11);
      n = $urandom_range(1, 3);
      case (r)
        6:  a = base_of(d) + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
        7:  a = base_of(d) + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 15));
        8:  a = $urandom;
        9:  a = base_of(d) + 32'(4 * (DEPTH - 1));
        default: a = base_of(d) + 32'(4 * $urandom_range(0, DEPTH - 1));
      endcase
      if (r == 10 && d == 0) begin
        abort0(a);
      end else if (r == 11) begin
        load(AW'($urandom_range(0, DEPTH - 1)), $urandom);
      end else begin
        fetch_seq(d, a, n, ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 2) == 0));
      end
    end

    repeat (5) @(negedge clk);
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: got %0d/%0d pending, required 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
